code_loader: RTL
================

Name: code_loader

Overview:
- Writer side of the code segment. Receives a framed byte stream, for example from a UART receiver.
- Assembles 16-bit instruction words, big-endian, and writes them into the code RAM write port.
- Holds the processor's active-low START low while loading. Releases it only after a frame passes its checksum.
- Sits between the host link and the `processor`/`code_seg` pair.

Parameters:
- HEADER, 8'hA5: frame start byte.
- BASE_ADDR, 8'h00: code address of the first loaded word.
- TIMEOUT_CYCLES, 1024: inter-byte timeout limit. Used only with LOADER_TIMEOUT_EN.

Ports:
- proc_clock  in  1  sole clock.
- START  in  1  reset; synchronous, active-low.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  RX_DATA is valid.
- RX_READY  out  1  loader accepts a byte this cycle.
- CODE_ADDR  out  8  code RAM write address.
- CODE_WDATA  out  16  instruction word.
- CODE_WREN  out  1  one-cycle write strobe.
- PROC_START_N  out  1  to processor START; low holds it in reset.
- DONE  out  1  last frame loaded and checksum correct.
- ERROR  out  1  last frame aborted (bad length, bad checksum, timeout).
- WORD_COUNT  out  8  words written in the current or last frame.

Behaviour:
- Interface: clock port proc_clock; reset port START, synchronous, active-low. A reset, including one mid-frame, takes effect at the next rising edge.
- Reset values: state IDLE, RX_READY=1, CODE_WREN=0, CODE_ADDR=BASE_ADDR, CODE_WDATA=0, PROC_START_N=0, DONE=0, ERROR=0, WORD_COUNT=0.
- Byte handshake: a byte is accepted on a rising edge where RX_VALID&RX_READY. At most one byte is accepted per cycle.
- States: IDLE, LEN, HI, LO, WRITE, CSUM, DONE, ERR.
- IDLE:
  - Accepted byte == HEADER: go to LEN; PROC_START_N=0, DONE=0, ERROR=0, checksum=0, WORD_COUNT=0.
  - Any other byte: discarded.
- LEN: latch N.
  - N==0: go to ERR.
  - Otherwise: go to HI.
- HI: latch the high byte; checksum ^= byte; go to LO.
- LO: latch the low byte; checksum ^= byte; go to WRITE.
- WRITE: exactly one cycle.
  - RX_READY=0, CODE_WREN=1, CODE_ADDR=BASE_ADDR+WORD_COUNT (mod 256), CODE_WDATA={hi,lo}.
  - WORD_COUNT increments at the end of the cycle.
  - Next state is CSUM if the new count == N, otherwise HI.
- Address range: addresses wrap mod 256. Words past 8'hFF overwrite from 8'h00; no error is raised.
- CSUM: accepted byte compared with the XOR of all 2N payload bytes.
  - Match: go to DONE.
  - Mismatch: go to ERR.
- DONE: DONE=1, PROC_START_N=1 (registered, rises the cycle DONE is entered), RX_READY=1.
- ERR: ERROR=1, PROC_START_N stays 0, RX_READY=1.
- Reload from DONE or ERR:
  - HEADER accepted: next state LEN, PROC_START_N=0 the same edge, DONE/ERROR cleared.
  - Any other byte: discarded.
- Per-frame write count: CODE_WREN pulses exactly N times per frame and is never asserted outside WRITE.
- Aborted frames: words already written stay in RAM; the processor stays held.
- Throughput: one word per 3 cycles when RX_VALID is held high.

Optional Feature:
- LOADER_TIMEOUT_EN defined:
  - A counter runs in LEN/HI/LO/CSUM and resets on every accepted byte.
  - When it reaches TIMEOUT_CYCLES, go to ERR the next edge.
- LOADER_TIMEOUT_EN undefined:
  - No counter; the loader waits indefinitely mid-frame.
  - TIMEOUT_CYCLES has no effect.

Decomposition:
- Package loader_pkg holds: the state enum typedef, the default HEADER constant, and the word typedef logic[15:0].
- Single module; the timeout counter is inline under the macro.
- No sub-module is warranted.

Test Plan:
- Frame A5,02,12,34,AB,CD,checksum 12^34^AB^CD=40 -> CODE_WREN pulses twice: (addr 00, 1234), then (01, ABCD). DONE=1, PROC_START_N=1, WORD_COUNT=2.
- Same frame with checksum 41 -> ERROR=1, PROC_START_N=0, both words written.
- Bytes 00,FF,A5,00 -> first two discarded, ERR on zero length, no CODE_WREN.
- START low after the HI byte of word 1, then frame A5,01,E0,00,E0 -> state IDLE; single write (00, E000); DONE=1.
- Back-to-back RX_VALID=1 -> RX_READY drops exactly in each WRITE cycle; no byte lost or duplicated.
- LOADER_TIMEOUT_EN with TIMEOUT_CYCLES=16, stream stalls after the LEN byte -> ERROR=1 after 16 cycles. Without the macro: still waiting after 1000 cycles.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the code loader
// Contents: loader_state_t (FSM states), HEADER_DEFAULT (frame start byte),
//           word_t (16-bit instruction word).
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } loader_state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef logic [15:0] word_t;

endpackage

// File: rtl/code_loader.sv
// rtl/code_loader.sv - framed byte stream to code RAM writer, holds processor in reset while loading
// Frame: HEADER, N, N x {hi, lo}, XOR checksum of the 2N payload bytes.
// Ports:
//   proc_clock   in   clock
//   START        in   synchronous active-low reset
//   RX_DATA/RX_VALID/RX_READY  byte input handshake
//   CODE_ADDR/CODE_WDATA/CODE_WREN  code RAM write port
//   PROC_START_N out  low holds the processor in reset
//   DONE/ERROR   out  result of the last frame
//   WORD_COUNT   out  words written in the current or last frame
// Optional: define LOADER_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES idle cycles.
module code_loader
    import loader_pkg::*;
#(
    parameter logic [7:0] HEADER         = HEADER_DEFAULT,
    parameter logic [7:0] BASE_ADDR      = 8'h00,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic        proc_clock,
    input  logic        START,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic        RX_READY,
    output logic [7:0]  CODE_ADDR,
    output word_t       CODE_WDATA,
    output logic        CODE_WREN,
    output logic        PROC_START_N,
    output logic        DONE,
    output logic        ERROR,
    output logic [7:0]  WORD_COUNT
);

    loader_state_t r_state, w_next;

    logic [7:0] r_len;
    logic [7:0] r_hi;
    logic [7:0] r_lo;
    logic [7:0] r_csum;
    logic [7:0] r_word_count;
    logic       r_done;
    logic       r_error;
    logic       r_proc_start_n;

    logic       w_rx_ready;
    logic       w_accept;
    logic       w_timeout;

    assign w_accept = RX_VALID & w_rx_ready;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_timer;
    logic          w_waiting;

    // Only the states that wait on the host for the rest of a frame are timed.
    assign w_waiting = (r_state == ST_LEN) || (r_state == ST_HI) ||
                       (r_state == ST_LO)  || (r_state == ST_CSUM);
    assign w_timeout = w_waiting && (r_timer == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge proc_clock) begin
        if (!START || !w_waiting || w_accept) begin
            r_timer <= '0;
        end else if (!w_timeout) begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge proc_clock) begin
        if (!START) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = ST_ERR;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_accept && RX_DATA == HEADER) w_next = ST_LEN;
                end
                ST_LEN: begin
                    if (w_accept) w_next = (RX_DATA == 8'h00) ? ST_ERR : ST_HI;
                end
                ST_HI: begin
                    if (w_accept) w_next = ST_LO;
                end
                ST_LO: begin
                    if (w_accept) w_next = ST_WRITE;
                end
                ST_WRITE: begin
                    w_next = (r_word_count + 8'd1 == r_len) ? ST_CSUM : ST_HI;
                end
                ST_CSUM: begin
                    if (w_accept) w_next = (RX_DATA == r_csum) ? ST_DONE : ST_ERR;
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Output decode
    always_comb begin
        w_rx_ready = 1'b1;
        CODE_WREN  = 1'b0;
        if (r_state == ST_WRITE) begin
            w_rx_ready = 1'b0;
            CODE_WREN  = 1'b1;
        end
    end

    // Datapath; result flags are registered from the next state so they
    // change on the same edge the FSM enters DONE/ERR or leaves for LEN.
    always_ff @(posedge proc_clock) begin
        if (!START) begin
            r_len          <= '0;
            r_hi           <= '0;
            r_lo           <= '0;
            r_csum         <= '0;
            r_word_count   <= '0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_proc_start_n <= 1'b0;
        end else begin
            r_done         <= (w_next == ST_DONE);
            r_error        <= (w_next == ST_ERR);
            r_proc_start_n <= (w_next == ST_DONE);
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_accept && RX_DATA == HEADER) begin
                        r_csum       <= '0;
                        r_word_count <= '0;
                    end
                end
                ST_LEN: if (w_accept) r_len <= RX_DATA;
                ST_HI: begin
                    if (w_accept) begin
                        r_hi   <= RX_DATA;
                        r_csum <= r_csum ^ RX_DATA;
                    end
                end
                ST_LO: begin
                    if (w_accept) begin
                        r_lo   <= RX_DATA;
                        r_csum <= r_csum ^ RX_DATA;
                    end
                end
                ST_WRITE: r_word_count <= r_word_count + 8'd1;
                default: ;
            endcase
        end
    end

    assign RX_READY     = w_rx_ready;
    assign CODE_ADDR    = BASE_ADDR + r_word_count;
    assign CODE_WDATA   = {r_hi, r_lo};
    assign PROC_START_N = r_proc_start_n;
    assign DONE         = r_done;
    assign ERROR        = r_error;
    assign WORD_COUNT   = r_word_count;

endmodule
